oflow_fsm_buffer_fill: RTL
==========================

# oflow_fsm_buffer_fill

Write-side companion of the buffer read-offset FSM. It accepts one frame's worth of object entries from the core, writes them into the history slot `frame_num % num_of_history_frames` of the MEM buffer, and maintains the per-slot `end_pointers[5]` consumed by the offset-generation FSM. It sits between the core FSM/object source and the MEM buffer wrapper, upstream of the read-offset stage.

## Interface
Parameters:
- `DATA_WIDTH`, default 64: width of one object entry.
- `MAX_ENTRIES`, default `2**OFFSET_WIDTH`: capacity of one history slot, in entries.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `reset_N`  in  1: synchronous, active-low reset.
- `frame_num`  in  `TOTAL_FRAME_NUM_WIDTH`: serial number of the current frame, 0-255.
- `num_of_history_frames`  in  `NUM_OF_HISTORY_FRAMES_WIDTH`: number of active slots, 1-5; a value of 0 is treated as 1.
- `start_frame`  in  1: one-cycle pulse that opens a frame.
- `data_valid`  in  1: `obj_data` is valid this cycle.
- `obj_data`  in  `DATA_WIDTH`: object entry.
- `end_frame`  in  1: one-cycle pulse that closes the frame; may coincide with a final `data_valid`.
- `ready_to_write`  out  1: high while in WRITE.
- `we`  out  1: buffer write enable, registered.
- `wr_slot`  out  3: target history slot, registered.
- `wr_offset`  out  `OFFSET_WIDTH`: entry offset within the slot, registered.
- `wr_data`  out  `DATA_WIDTH`: registered copy of `obj_data`.
- `end_pointers[5]`  out  `ADDR_WIDTH` each: number of valid entries per slot.
- `frame_done`  out  1: one-cycle pulse, high in CLOSE.
- `overflow`  out  1: sticky flag, cleared at the next accepted `start_frame`.

## Operation
- States are IDLE, WRITE and CLOSE.
- **IDLE**
  - `start_frame` latches `slot = frame_num % max(num_of_history_frames,1)`.
  - It clears `count`, clears `end_pointers[slot]` and clears `overflow`, then moves to WRITE.
  - `data_valid` and `end_frame` are ignored in IDLE.
- **WRITE**
  - On `data_valid` with `count < MAX_ENTRIES`: write `obj_data` at offset `count`, then `count <= count+1`.
  - On `data_valid` with `count == MAX_ENTRIES`: drop the entry, hold `count`, set `overflow`.
  - On `end_frame`:
    - `end_pointers[slot] <= count_next`, where `count_next` includes a same-cycle accepted beat.
    - Move to CLOSE.
  - `start_frame` in WRITE is ignored; the frame continues.
- **CLOSE**: `frame_done=1` for exactly one cycle, then return to IDLE unconditionally.
- **Slot isolation**: the `end_pointers` of non-target slots are never modified. The slot's pointer reads 0 from start until close.
- **Arithmetic**
  - `count` is `OFFSET_WIDTH+1` bits so that it can hold `MAX_ENTRIES`.
  - `end_pointers` are zero-extended to `ADDR_WIDTH`.
  - The modulo is taken on the full 8-bit `frame_num`.
- **Reset**: reset asserted at any point, including mid-frame, forces the following:
  - state returns to IDLE;
  - `count`, all `end_pointers`, `we`, `wr_slot`, `wr_offset`, `wr_data`, `frame_done` and `overflow` go to 0;
  - a partial frame is discarded.

## Timing
- Reset values of all outputs are 0.
- `start_frame` in cycle t gives state WRITE and `ready_to_write=1` in cycle t+1.
- An accepted `data_valid` at cycle t gives `we=1` with the matching `wr_offset`/`wr_slot`/`wr_data` at t+1; latency is 1.
- Back-to-back beats are accepted every cycle, so throughput is 1 entry per cycle.
- `end_frame` at t gives CLOSE, `frame_done=1` and the updated `end_pointers[slot]` visible at t+1, and IDLE at t+2.
- The earliest next accepted `start_frame` is at t+2.
- The write of the last beat (`we` at t+1) coincides with `frame_done`.
- An empty frame (`end_frame` with no beats) gives `end_pointers[slot]=0` and `frame_done`, with no `we`.

## Structure
- Shared package `oflow_MEM_buffer_define.sv`:
  - `ADDR_WIDTH`, `OFFSET_WIDTH`, `TOTAL_FRAME_NUM_WIDTH`, `NUM_OF_HISTORY_FRAMES_WIDTH`;
  - a new `MAX_HISTORY_SLOTS` (=5);
  - the state enum typedef.
- One sub-module, `oflow_history_slot_sel`: combinational `frame_num % n` for n in 1..5. It is implemented by compare/subtract, with no divider, and is reusable by the read side.

## Test plan
- Reset, then `start_frame` with `frame_num=7` and nhf=5, then 4 beats and `end_frame` on the 4th. Required: `we` on offsets 0-3 in slot 2, `end_pointers[2]=4`, `frame_done` one cycle, other slots 0.
- `frame_num=255`, nhf=3, 0 beats, then `end_frame`. Required: slot 0, `end_pointers[0]=0`, `frame_done` asserted, no `we`.
- nhf=0, `frame_num=9`. Required: slot 0 is used.
- `MAX_ENTRIES+2` beats. Required: exactly `MAX_ENTRIES` writes, `end_pointers[slot]=MAX_ENTRIES`, `overflow=1` until the next `start_frame`.
- Frame A in slot 1 with 6 entries, then frame B in slot 3 with 2 entries. Required: `end_pointers[1]` stays 6, `end_pointers[3]=2`; `start_frame` pulsed mid-B is ignored.
- `reset_N` low after 3 beats mid-frame. Required: next cycle all outputs 0 and state IDLE; a new frame then behaves normally.

Source files
------------

// File: rtl/oflow_fsm_buffer_fill_pkg.sv
// Shared definitions for the write side of the object history buffer.
// Holds the buffer geometry, the frame/slot counter widths and the state
// type of the buffer-fill FSM. The read-offset stage imports the same values.
package oflow_fsm_buffer_fill_pkg;

    localparam int unsigned ADDR_WIDTH                  = 8;
    localparam int unsigned OFFSET_WIDTH                = 4;
    localparam int unsigned TOTAL_FRAME_NUM_WIDTH       = 8;
    localparam int unsigned NUM_OF_HISTORY_FRAMES_WIDTH = 3;
    localparam int unsigned MAX_HISTORY_SLOTS           = 5;
    localparam int unsigned SLOT_WIDTH                  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StClose
    } fill_state_e;

endpackage

// File: rtl/oflow_fsm_buffer_fill_if.sv
// Handshake and buffer-write bundle between the core/object source (master)
// and the buffer-fill FSM (slave).
//   master drives : frame_num, num_of_history_frames, start_frame, data_valid,
//                   obj_data, end_frame
//   slave drives  : ready_to_write, we, wr_slot, wr_offset, wr_data,
//                   end_pointers[5], frame_done, overflow
interface oflow_fsm_buffer_fill_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    import oflow_fsm_buffer_fill_pkg::*;

    logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num;
    logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames;
    logic                                   start_frame;
    logic                                   data_valid;
    logic [DATA_WIDTH-1:0]                  obj_data;
    logic                                   end_frame;

    logic                                   ready_to_write;
    logic                                   we;
    logic [SLOT_WIDTH-1:0]                  wr_slot;
    logic [OFFSET_WIDTH-1:0]                wr_offset;
    logic [DATA_WIDTH-1:0]                  wr_data;
    logic [ADDR_WIDTH-1:0]                  end_pointers [MAX_HISTORY_SLOTS];
    logic                                   frame_done;
    logic                                   overflow;

    modport master (
        output frame_num, num_of_history_frames, start_frame, data_valid, obj_data, end_frame,
        input  ready_to_write, we, wr_slot, wr_offset, wr_data, end_pointers, frame_done,
               overflow
    );

    modport slave (
        input  frame_num, num_of_history_frames, start_frame, data_valid, obj_data, end_frame,
        output ready_to_write, we, wr_slot, wr_offset, wr_data, end_pointers, frame_done,
               overflow
    );

endinterface

// File: rtl/oflow_fsm_buffer_fill_history_slot_sel.sv
// History slot selector: slot_o = frame_num_i % n, with n = num_slots_i
// clamped to 1..5 (0 reads as 1). Purely combinational, built as a restoring
// bit-serial remainder (shift in one bit, conditionally subtract) so no
// divider is inferred. Shared with the read side.
//   frame_num_i  : 8-bit frame serial number
//   num_slots_i  : number of active history slots
//   slot_o       : selected slot, 0..4
module oflow_history_slot_sel
    import oflow_fsm_buffer_fill_pkg::*;
(
    input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num_i,
    input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_slots_i,
    output logic [SLOT_WIDTH-1:0]                  slot_o
);

    localparam logic [3:0] MaxSlots = 4'(MAX_HISTORY_SLOTS);

    logic [3:0] divisor;
    logic [3:0] rem;

    always_comb begin
        divisor = 4'(num_slots_i);
        if (num_slots_i == '0) begin
            divisor = 4'd1;
        end else if (divisor > MaxSlots) begin
            divisor = MaxSlots;
        end

        // rem stays below the divisor (<= 4), so the shifted value fits 4 bits.
        rem = '0;
        for (int i = TOTAL_FRAME_NUM_WIDTH - 1; i >= 0; i--) begin
            rem = {rem[2:0], frame_num_i[i]};
            if (rem >= divisor) begin
                rem = rem - divisor;
            end
        end
        slot_o = rem[SLOT_WIDTH-1:0];
    end

endmodule

// File: rtl/oflow_fsm_buffer_fill.sv
// Buffer-fill FSM: accepts one frame of object entries, writes them into
// history slot frame_num % num_of_history_frames and publishes the per-slot
// entry counts (end_pointers) for the read-offset stage.
//   clk      : clock, posedge
//   reset_N  : synchronous active-low reset
//   bus      : slave side of oflow_fsm_buffer_fill_if (frame control, object
//              data in; buffer write port, end_pointers, status out)
module oflow_fsm_buffer_fill
    import oflow_fsm_buffer_fill_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned MAX_ENTRIES = 2 ** OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_N,
    oflow_fsm_buffer_fill_if.slave  bus
);

    localparam logic [OFFSET_WIDTH:0] MaxCount = (OFFSET_WIDTH + 1)'(MAX_ENTRIES);

    fill_state_e                 state_q;
    logic [SLOT_WIDTH-1:0]       slot_q;
    logic [OFFSET_WIDTH:0]       count_q;
    logic [OFFSET_WIDTH:0]       count_d;
    logic                        accept;
    logic [ADDR_WIDTH-1:0]       end_ptr_q [MAX_HISTORY_SLOTS];
    logic                        ready_q;
    logic                        we_q;
    logic [SLOT_WIDTH-1:0]       wr_slot_q;
    logic [OFFSET_WIDTH-1:0]     wr_offset_q;
    logic [DATA_WIDTH-1:0]       wr_data_q;
    logic                        frame_done_q;
    logic                        overflow_q;
    logic [SLOT_WIDTH-1:0]       slot_sel;

    oflow_history_slot_sel u_slot_sel (
        .frame_num_i (bus.frame_num),
        .num_slots_i (bus.num_of_history_frames),
        .slot_o      (slot_sel)
    );

    // count_d includes a beat accepted in the same cycle as end_frame.
    always_comb begin
        accept  = (state_q == StWrite) && bus.data_valid && (count_q < MaxCount);
        count_d = count_q + {{OFFSET_WIDTH{1'b0}}, accept};
    end

    always_ff @(posedge clk) begin
        if (!reset_N) begin
            state_q      <= StIdle;
            slot_q       <= '0;
            count_q      <= '0;
            ready_q      <= 1'b0;
            we_q         <= 1'b0;
            wr_slot_q    <= '0;
            wr_offset_q  <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < MAX_HISTORY_SLOTS; i++) begin
                end_ptr_q[i] <= '0;
            end
        end else begin
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start_frame) begin
                        slot_q              <= slot_sel;
                        count_q             <= '0;
                        end_ptr_q[slot_sel] <= '0;
                        overflow_q          <= 1'b0;
                        ready_q             <= 1'b1;
                        state_q             <= StWrite;
                    end
                end
                StWrite: begin
                    if (bus.data_valid) begin
                        if (accept) begin
                            we_q        <= 1'b1;
                            wr_slot_q   <= slot_q;
                            wr_offset_q <= count_q[OFFSET_WIDTH-1:0];
                            wr_data_q   <= bus.obj_data;
                        end else begin
                            overflow_q  <= 1'b1;
                        end
                    end
                    count_q <= count_d;
                    if (bus.end_frame) begin
                        end_ptr_q[slot_q] <= ADDR_WIDTH'(count_d);
                        ready_q           <= 1'b0;
                        frame_done_q      <= 1'b1;
                        state_q           <= StClose;
                    end
                end
                StClose: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.ready_to_write = ready_q;
    assign bus.we             = we_q;
    assign bus.wr_slot        = wr_slot_q;
    assign bus.wr_offset      = wr_offset_q;
    assign bus.wr_data        = wr_data_q;
    assign bus.end_pointers   = end_ptr_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.overflow       = overflow_q;

endmodule
